// File: rtl/timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and defaults.
package timer_pkg;

    localparam int TIMER_WIDTH_DEF      = 16;
    localparam int TIMER_PRESCALE_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_e;

endpackage : timer_pkg

// File: rtl/down_timer_prescale_tick.sv
// Prescale divider: emits one tick every prescale+1 clocks while enabled.
// The divide setting is compared live, so a shrinking setting below the
// current counter value makes the counter run on through its maximum and wrap,
// rather than firing an early tick.
module prescale_tick
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = TIMER_PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    assign tick = en && (pcnt_q == prescale);

    // Next value: clear wins, otherwise count while enabled and wrap on tick.
    always_comb begin
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            if (tick) pcnt_d = '0;
            else      pcnt_d = pcnt_q + PRESCALE_W'(1);
        end
    end

    // Prescale counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

endmodule : prescale_tick

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Command priority on each edge is load > stop > start > tick. A load is
// applied first and any same-edge start is judged against the loaded value.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = TIMER_WIDTH_DEF,
    parameter int PRESCALE_W = TIMER_PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc_pulse,
    output logic                  busy,
    output logic                  expired
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             clr;
    logic             tick;

    prescale_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_q == ST_RUN),
        .clr      (clr),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next-state, count and terminal-pulse decode in command priority order.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        clr      = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            clr      = 1'b1;
            if (state_q == ST_DONE || (state_q == ST_RUN && load_val == '0))
                state_d = ST_IDLE;
            if (start && state_d == ST_IDLE && load_val != '0)
                state_d = ST_RUN;
        end else if (stop) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
        end else if (start && state_q == ST_IDLE) begin
            if (count_q != '0) begin
                state_d = ST_RUN;
                clr     = 1'b1;
            end
        end else if (state_q == ST_RUN && tick) begin
            if (count_q > WIDTH'(1)) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_DONE;
                end
            end
        end
    end

    // State, count, reload and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count    = count_q;
    assign tc_pulse = tc_q;
    assign busy     = (state_q == ST_RUN);
    assign expired  = (state_q == ST_DONE);

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle to a model.
module tb_down_timer;

    localparam int W  = 16;
    localparam int PW = 8;

    logic          clk, rst_n;
    logic          load, start, stop, auto_reload;
    logic [W-1:0]  load_val;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count;
    logic          tc_pulse, busy, expired;

    int n_cmp = 0;
    int n_bad = 0;

    down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .tc_pulse    (tc_pulse),
        .busy        (busy),
        .expired     (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode is 0 idle, 1 running, 2 finished.
    int m_mode, m_cnt, m_rld, m_phase;
    bit m_tc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_rld = 0; m_phase = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_cnt = int'(load_val); m_rld = int'(load_val); m_phase = 0;
                if (m_mode == 2 || (m_mode == 1 && m_cnt == 0)) m_mode = 0;
                if (start && m_mode == 0 && m_cnt != 0) m_mode = 1;
            end else if (stop) begin
                m_mode = 0; m_phase = 0;
            end else if (start && m_mode == 0) begin
                if (m_cnt != 0) begin m_mode = 1; m_phase = 0; end
            end else if (m_mode == 1) begin
                if (m_phase == int'(prescale)) begin
                    m_phase = 0;
                    if (m_cnt > 1) m_cnt = m_cnt - 1;
                    else begin
                        m_tc = 1;
                        if (auto_reload) m_cnt = m_rld;
                        else begin m_cnt = 0; m_mode = 2; end
                    end
                end else begin
                    m_phase = (m_phase + 1) % (1 << PW);
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("m_count",   32'(count),    32'(m_cnt));
        chk("m_tc",      32'(tc_pulse), 32'(m_tc));
        chk("m_busy",    32'(busy),     32'(m_mode == 1));
        chk("m_expired", 32'(expired),  32'(m_mode == 2));
    end

    task automatic cyc(input bit l, input logic [W-1:0] lv, input bit s, input bit sp);
        load = l; load_val = lv; start = s; stop = sp;
        @(negedge clk);
        load = 0; start = 0; stop = 0;
    endtask

    initial begin : main
        int ntc, first, busybad;
        rst_n = 0; load = 0; load_val = '0; start = 0; stop = 0;
        auto_reload = 0; prescale = '0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_tc", 32'(tc_pulse), 0);
        @(negedge clk); rst_n = 1;

        // One-shot, load 3, prescale 0.
        cyc(1, 16'd3, 0, 0);
        chk("os_load", 32'(count), 3);
        cyc(0, 0, 1, 0);
        chk("os_start_cnt", 32'(count), 3);
        chk("os_start_busy", 32'(busy), 1);
        @(negedge clk); chk("os_c2", 32'(count), 2);
        @(negedge clk); chk("os_c1", 32'(count), 1);
        @(negedge clk);
        chk("os_c0", 32'(count), 0);
        chk("os_tc", 32'(tc_pulse), 1);
        chk("os_exp", 32'(expired), 1);
        @(negedge clk);
        chk("os_tc_off", 32'(tc_pulse), 0);
        chk("os_hold", 32'(count), 0);
        cyc(0, 0, 1, 0);
        chk("done_start_ign", 32'(expired), 1);

        // Auto-reload, load 4, prescale 2: pulse every 12 clocks.
        prescale = 8'd2; auto_reload = 1;
        cyc(1, 16'd4, 0, 0);
        chk("ar_load_idle", 32'(expired), 0);
        cyc(0, 0, 1, 0);
        ntc = 0; first = 0; busybad = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (tc_pulse) begin ntc++; if (first == 0) first = k; end
            if (!busy) busybad++;
        end
        chk("ar_ntc", 32'(ntc), 3);
        chk("ar_first", 32'(first), 12);
        chk("ar_busy", 32'(busybad), 0);
        chk("ar_reload", 32'(count), 4);
        cyc(0, 0, 0, 1);
        chk("ar_stop", 32'(busy), 0);

        // Collisions.
        prescale = '0; auto_reload = 0;
        cyc(1, 16'd7, 1, 0);
        chk("ls_busy", 32'(busy), 1);
        chk("ls_cnt", 32'(count), 7);
        cyc(1, 16'd9, 0, 1);
        chk("lstop_busy", 32'(busy), 1);
        chk("lstop_cnt", 32'(count), 9);
        cyc(1, 16'd0, 0, 0);
        chk("l0_busy", 32'(busy), 0);
        chk("l0_tc", 32'(tc_pulse), 0);

        // Stop and restart.
        cyc(1, 16'd5, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("sr_cnt2", 32'(count), 2);
        cyc(0, 0, 0, 1);
        chk("sr_idle", 32'(busy), 0);
        chk("sr_hold", 32'(count), 2);
        cyc(0, 0, 1, 0);
        chk("sr_resume", 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        chk("sr_tc", 32'(tc_pulse), 1);

        // Width edges.
        cyc(1, 16'hFFFF, 0, 0);
        cyc(0, 0, 1, 0);
        @(negedge clk);
        chk("wr_fffe", 32'(count), 32'hFFFE);
        cyc(0, 0, 0, 1);
        cyc(1, 16'd1, 0, 0);
        cyc(0, 0, 1, 0);
        @(negedge clk);
        chk("one_tc", 32'(tc_pulse), 1);
        chk("one_exp", 32'(expired), 1);
        cyc(0, 0, 1, 0);
        chk("done_ign2", 32'(expired), 1);
        cyc(1, 16'd2, 0, 0);
        chk("done_load", 32'(expired), 0);

        // Reset in the middle of a run.
        prescale = 8'd3;
        cyc(1, 16'd5, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("mr_count", 32'(count), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_exp", 32'(expired), 0);
        chk("mr_tc", 32'(tc_pulse), 0);
        @(negedge clk); rst_n = 1;
        cyc(0, 0, 1, 0);
        chk("mr_start0", 32'(busy), 0);

        // Randomized traffic.
        prescale = '0;
        for (int i = 0; i < 4000; i++) begin
            load     = ($urandom % 20) == 0;
            load_val = (($urandom % 4) == 0) ? W'($urandom) : W'($urandom % 8);
            start    = ($urandom % 4) == 0;
            stop     = ($urandom % 25) == 0;
            if (($urandom % 40) == 0)
                prescale = (($urandom % 10) == 0) ? PW'($urandom) : PW'($urandom % 4);
            if (($urandom % 30) == 0) auto_reload = 1'($urandom % 2);
            @(negedge clk);
        end
        load = 0; start = 0; stop = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_down_timer
